// File: rtl/timer_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : timer_multi                                                 |
// | Description: Shared 1 ms prescaler feeding CHANNELS programmable         |
// |              one-shot/periodic down-counters with 1-cycle expiry pulses. |
// |              Optional sticky IRQ block under `TIMER_MULTI_IRQ_EN`.       |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module timer_multi #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int CHANNELS    = 4,
   parameter int MS_WIDTH    = 16,
   parameter int DEFAULT_MS  = 1
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic                                cfg_we,
   input  logic [($clog2(CHANNELS) | 1)-1:0]   cfg_ch,
   input  logic [MS_WIDTH-1:0]                 cfg_ms,
   input  logic                                cfg_mode,
   input  logic [CHANNELS-1:0]                 start,
   input  logic [CHANNELS-1:0]                 stop,
   output logic [CHANNELS-1:0]                 sig_out,
`ifdef TIMER_MULTI_IRQ_EN
   input  logic [CHANNELS-1:0]                 irq_clr,
   output logic [CHANNELS-1:0]                 irq_status,
   output logic                                irq_out,
`endif
   output logic [CHANNELS-1:0]                 busy
);

   localparam int c_ticks_per_ms = CLK_FREQ_HZ / 1000;
   localparam int c_ps_w         = $clog2(c_ticks_per_ms);
   localparam int c_ch_w         = $clog2(CHANNELS) | 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   logic [c_ps_w-1:0]   r_ps;
   logic                w_ms_tick;
   logic [CHANNELS-1:0] w_pulse_vec;
   logic [CHANNELS-1:0] r_sig;

   assign w_ms_tick = (r_ps == c_ps_w'(c_ticks_per_ms - 1));

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_ps <= '0;
      end else if (w_ms_tick) begin
         r_ps <= '0;
      end else begin
         r_ps <= r_ps + c_ps_w'(1);
      end
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      state_t              r_state;
      state_t              w_state_nxt;
      logic [MS_WIDTH-1:0] r_cnt;
      logic [MS_WIDTH-1:0] w_cnt_nxt;
      logic [MS_WIDTH-1:0] r_period;
      logic                r_mode;
      logic                w_pulse;
      logic                w_cfg_sel;

      assign w_cfg_sel = cfg_we && (cfg_ch == c_ch_w'(gi));

      always_ff @(posedge clk_in) begin
         if (rst_in) begin
            r_period <= MS_WIDTH'(DEFAULT_MS);
            r_mode   <= 1'b0;
         end else if (w_cfg_sel) begin
            r_period <= cfg_ms;
            r_mode   <= cfg_mode;
         end
      end

      always_ff @(posedge clk_in) begin
         if (rst_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_pulse     = 1'b0;
         if (stop[gi]) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end else if (start[gi] && (r_period != '0)) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = r_period;
         end else if ((r_state == ST_RUN) && w_ms_tick) begin
            if (r_cnt == MS_WIDTH'(1)) begin
               w_pulse = 1'b1;
               // A periodic channel reprogrammed to 0 ms cannot reload, so it retires.
               if (r_mode && (r_period != '0)) begin
                  w_cnt_nxt = r_period;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end
            end else if (r_cnt > MS_WIDTH'(1)) begin
               w_cnt_nxt = r_cnt - MS_WIDTH'(1);
            end
         end
      end

      assign w_pulse_vec[gi] = w_pulse;
      assign busy[gi]        = (r_state == ST_RUN);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_sig <= '0;
      end else begin
         r_sig <= w_pulse_vec;
      end
   end

   assign sig_out = r_sig;

`ifdef TIMER_MULTI_IRQ_EN
   logic [CHANNELS-1:0] r_irq_status;
   logic [CHANNELS-1:0] w_irq_nxt;
   logic                r_irq_out;

   // New expiries are OR-ed in after the clear so a coincident set wins.
   assign w_irq_nxt = (r_irq_status & ~irq_clr) | w_pulse_vec;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_irq_status <= '0;
         r_irq_out    <= 1'b0;
      end else begin
         r_irq_status <= w_irq_nxt;
         r_irq_out    <= |w_irq_nxt;
      end
   end

   assign irq_status = r_irq_status;
   assign irq_out    = r_irq_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_timer_multi                                              |
// | Description: Directed self-checking bench for timer_multi (10 clk/ms).   |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_timer_multi;

   localparam int CH = 4;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          cfg_we;
   logic [2:0]    cfg_ch;
   logic [15:0]   cfg_ms;
   logic          cfg_mode;
   logic [CH-1:0] start;
   logic [CH-1:0] stop;
   logic [CH-1:0] sig_out;
   logic [CH-1:0] busy;
`ifdef TIMER_MULTI_IRQ_EN
   logic [CH-1:0] irq_clr;
   logic [CH-1:0] irq_status;
   logic          irq_out;
`endif

   int checks   = 0;
   int failures = 0;
   int bp       = 0;

   always #5 clk_in = ~clk_in;

   timer_multi #(
      .CLK_FREQ_HZ (10_000),
      .CHANNELS    (CH),
      .MS_WIDTH    (16),
      .DEFAULT_MS  (1)
   ) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_ms     (cfg_ms),
      .cfg_mode   (cfg_mode),
      .start      (start),
      .stop       (stop),
      .sig_out    (sig_out),
`ifdef TIMER_MULTI_IRQ_EN
      .irq_clr    (irq_clr),
      .irq_status (irq_status),
      .irq_out    (irq_out),
`endif
      .busy       (busy)
   );

   // Reference prescaler: value that the next rising edge will sample.
   always @(posedge clk_in) bp <= rst_in ? 0 : ((bp == 9) ? 0 : bp + 1);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nc();
      @(negedge clk_in);
   endtask

   task automatic sync0();
      for (int k = 0; k < 12; k++) begin
         if (bp == 0) break;
         nc();
      end
   endtask

   task automatic cfg(input int ch, input int ms, input logic mode);
      cfg_we   = 1'b1;
      cfg_ch   = 3'(ch);
      cfg_ms   = 16'(ms);
      cfg_mode = mode;
      nc();
      cfg_we   = 1'b0;
   endtask

   initial begin
      int bad;
      int pulses;
      logic exp_p;

      rst_in = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_ms = '0; cfg_mode = 1'b0;
      start = '0; stop = '0;
`ifdef TIMER_MULTI_IRQ_EN
      irq_clr = '0;
`endif
      repeat (3) nc();
      chk("reset_sig", 32'(sig_out), 0);
      chk("reset_busy", 32'(busy), 0);
      rst_in = 1'b0;

      // Reset mid-run aborts every channel silently
      nc(); sync0();
      start = 4'hF; nc(); start = '0;
      chk("run_busy_all", 32'(busy), 32'hF);
      nc(); nc();
      rst_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         nc();
         chk("midrst_sig", 32'(sig_out), 0);
         chk("midrst_busy", 32'(busy), 0);
      end
      rst_in = 1'b0;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         nc();
         if (sig_out !== '0 || busy !== '0) bad++;
      end
      chk("post_reset_quiet", 32'(bad), 0);

      // ch0 one-shot 3 ms started the cycle after a tick
      cfg(0, 3, 1'b0); sync0();
      start = 4'h1; nc(); start = '0;
      bad = 0;
      for (int k = 1; k <= 40; k++) begin
         if (sig_out[0] !== (k == 30) || busy[0] !== (k < 30)) bad++;
         if (k == 30) chk("oneshot_pulse", 32'({busy[0], sig_out[0]}), 32'b01);
         nc();
      end
      chk("oneshot_timeline", 32'(bad), 0);

      // ch1 periodic 2 ms, five pulses then stop
      cfg(1, 2, 1'b1); sync0();
      start = 4'h2; nc(); start = '0;
      bad = 0; pulses = 0;
      for (int k = 1; k <= 100; k++) begin
         if (sig_out[1] === 1'b1) pulses++;
         if (sig_out[1] !== (k % 20 == 0) || busy[1] !== 1'b1) bad++;
         if (k == 100) stop = 4'h2;
         nc();
      end
      stop = '0;
      chk("periodic_timeline", 32'(bad), 0);
      chk("periodic_count", 32'(pulses), 5);
      chk("periodic_stop_busy", 32'(busy[1]), 0);
      bad = 0;
      for (int k = 0; k < 60; k++) begin
         nc();
         if (sig_out[1] !== 1'b0 || busy[1] !== 1'b0) bad++;
      end
      chk("periodic_after_stop", 32'(bad), 0);

      // start and stop together leave the channel idle
      start = 4'h4; stop = 4'h4; nc(); start = '0; stop = '0;
      chk("start_stop_busy", 32'(busy[2]), 0);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         nc();
         if (sig_out[2] !== 1'b0 || busy[2] !== 1'b0) bad++;
      end
      chk("start_stop_quiet", 32'(bad), 0);

      // stop lands on the expiry edge of ch3 (default 1 ms one-shot)
      sync0();
      start = 4'h8; nc(); start = '0;
      repeat (8) nc();
      stop = 4'h8; nc(); stop = '0;
      chk("stop_expiry_sig", 32'(sig_out[3]), 0);
      chk("stop_expiry_busy", 32'(busy[3]), 0);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         nc();
         if (sig_out[3] !== 1'b0) bad++;
      end
      chk("stop_expiry_quiet", 32'(bad), 0);

      // zero period makes start a no-op
      cfg(2, 0, 1'b0);
      start = 4'h4; nc(); start = '0;
      chk("zero_period_busy", 32'(busy[2]), 0);
      repeat (5) nc();
      chk("zero_period_busy_later", 32'(busy[2]), 0);

      // out-of-range channel write changes nothing: ch3=1 ms, ch0=3 ms one-shots
      cfg(4, 7, 1'b1); sync0();
      start = 4'h9; nc(); start = '0;
      bad = 0;
      for (int k = 1; k <= 40; k++) begin
         if (sig_out[3] !== (k == 10) || sig_out[0] !== (k == 30)) bad++;
         nc();
      end
      chk("bad_cfg_ch_timeline", 32'(bad), 0);

      // ch2 periodic 4 ms, reprogrammed to 2 ms mid-interval
      cfg(2, 4, 1'b1); sync0();
      start = 4'h4; nc(); start = '0;
      bad = 0;
      for (int k = 1; k <= 125; k++) begin
         exp_p = (k == 40) || (k == 80) || (k == 100) || (k == 120);
         if (sig_out[2] !== exp_p) bad++;
         if (k == 80) chk("reprog_old_spacing", 32'(sig_out[2]), 1);
         if (k == 100) chk("reprog_new_spacing", 32'(sig_out[2]), 1);
         if (k == 45) begin
            cfg_we = 1'b1; cfg_ch = 3'd2; cfg_ms = 16'd2; cfg_mode = 1'b1;
         end else begin
            cfg_we = 1'b0;
         end
         nc();
      end
      chk("reprog_timeline", 32'(bad), 0);
      stop = 4'h4; nc(); stop = '0;
      chk("reprog_stop_busy", 32'(busy[2]), 0);

`ifdef TIMER_MULTI_IRQ_EN
      irq_clr = 4'hF; nc(); irq_clr = '0;
      nc();
      chk("irq_cleared", 32'(irq_status), 0);
      chk("irq_out_cleared", 32'(irq_out), 0);
      cfg(0, 2, 1'b0);
      cfg(3, 2, 1'b1); sync0();
      start = 4'h9; nc(); start = '0;
      repeat (19) nc();
      chk("irq_joint_sig", 32'(sig_out), 32'h9);
      chk("irq_joint_status", 32'(irq_status), 32'h9);
      nc();
      chk("irq_out_set", 32'(irq_out), 1);
      chk("irq_status_hold", 32'(irq_status), 32'h9);
      irq_clr = 4'h1; nc(); irq_clr = '0;
      chk("irq_clr_bit0", 32'(irq_status), 32'h8);
      repeat (17) nc();
      irq_clr = 4'h8; nc(); irq_clr = '0;
      chk("irq_set_vs_clr_sig", 32'(sig_out[3]), 1);
      chk("irq_set_beats_clr", 32'(irq_status), 32'h8);
      stop = 4'h8; nc(); stop = '0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
